// File: rtl/picorv32_wb_bridge_pkg.sv
// Shared types and constants for the picorv32 to Wishbone bridge.
// Holds the FSM encoding, the read select value and the default error read data.
package picorv32_wb_bridge_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } wb_state_e;

    localparam logic [3:0]  WB_SEL_ALL    = 4'hF;
    localparam logic [31:0] ERR_RDATA_DEF = 32'hDEADBEEF;

endpackage

// File: rtl/picorv32_wb_bridge_timeout.sv
// wb_timeout_counter: counts cycles while run=1, cleared by clear.
// Ports: i_clk, i_reset_n, i_run, i_clear in; o_expired out, high in the
// LIMIT-th consecutive run cycle (and held while run stays high).
module wb_timeout_counter
    import picorv32_wb_bridge_pkg::*;
#(
    parameter int unsigned LIMIT = 255,
    parameter int          WIDTH = $clog2(LIMIT + 1)
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_run,
    input  logic i_clear,
    output logic o_expired
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             at_limit;

    // The count lags the run cycle by one, so LIMIT-1 marks the LIMIT-th cycle.
    assign at_limit  = (cnt_q == WIDTH'(LIMIT - 1));
    assign o_expired = i_run && at_limit;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_run && !at_limit) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/picorv32_wb_bridge.sv
// picorv32 native memory port to single-master pipelined Wishbone B4 bridge.
// Ports: i_mem_* / o_mem_* to the CPU, o_wb_* / i_wb_* to the bus, o_bus_err / o_err_addr status.
module picorv32_wb_bridge
    import picorv32_wb_bridge_pkg::*;
#(
    parameter int unsigned  TIMEOUT   = 255,
    parameter logic [31:0]  ERR_RDATA = ERR_RDATA_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_mem_valid,
    input  logic        i_mem_instr,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    input  logic [3:0]  i_mem_wstrb,
    output logic        o_mem_ready,
    output logic [31:0] o_mem_rdata,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_data,
    input  logic        i_wb_stall,
    input  logic        i_wb_err,
    output logic        o_bus_err,
    output logic [31:0] o_err_addr
);

    localparam int TW = $clog2(TIMEOUT + 1);

    wb_state_e   state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        instr_q, instr_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] err_addr_q, err_addr_d;

    logic        tmo_expired;
    logic        done;
    logic        fail;
    logic        unused_instr;

    // Fetch flag is kept with the request for debug visibility only.
    assign unused_instr = instr_q;

    wb_timeout_counter #(
        .LIMIT (TIMEOUT),
        .WIDTH (TW)
    ) u_tmo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_run     (cyc_q),
        .i_clear   (state_q == S_IDLE),
        .o_expired (tmo_expired)
    );

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        we_d       = we_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        data_d     = data_q;
        instr_d    = instr_q;
        ready_d    = 1'b0;
        rdata_d    = '0;
        bus_err_d  = bus_err_q;
        err_addr_d = err_addr_q;
        done       = 1'b0;
        fail       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // ready_q blocks the request still held in the ready cycle.
                if (i_mem_valid && !ready_q) begin
                    addr_d  = i_mem_addr;
                    data_d  = i_mem_wdata;
                    we_d    = |i_mem_wstrb;
                    sel_d   = (|i_mem_wstrb) ? i_mem_wstrb : WB_SEL_ALL;
                    instr_d = i_mem_instr;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ, S_WAIT: begin
                if (state_q == S_REQ && !i_wb_stall) begin
                    stb_d   = 1'b0;
                    state_d = S_WAIT;
                end
                // err beats ack, ack beats a coincident timeout.
                if (i_wb_err) begin
                    done = 1'b1;
                    fail = 1'b1;
                end else if (i_wb_ack) begin
                    done = 1'b1;
                end else if (tmo_expired) begin
                    done = 1'b1;
                    fail = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end
        endcase

        if (done) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            state_d = S_IDLE;
            ready_d = 1'b1;
            if (!we_q) begin
                rdata_d = fail ? ERR_RDATA : i_wb_data;
            end
            if (fail) begin
                bus_err_d = 1'b1;
                if (!bus_err_q) begin
                    err_addr_d = addr_q;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            instr_q    <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            instr_q    <= instr_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            bus_err_q  <= bus_err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign o_mem_ready = ready_q;
    assign o_mem_rdata = rdata_q;
    assign o_wb_addr   = addr_q;
    assign o_wb_data   = data_q;
    assign o_wb_sel    = sel_q;
    assign o_wb_we     = we_q;
    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = stb_q;
    assign o_bus_err   = bus_err_q;
    assign o_err_addr  = err_addr_q;

endmodule

// File: tb/tb_picorv32_wb_bridge.sv
// Self-checking bench for picorv32_wb_bridge.
// Scripted slave plus bus monitor; expectations come from a cycle-count model.
module tb_picorv32_wb_bridge;

    localparam int          TMO  = 255;
    localparam logic [31:0] ERRV = 32'hDEADBEEF;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_mem_valid = 1'b0;
    logic        i_mem_instr = 1'b0;
    logic [31:0] i_mem_addr = '0;
    logic [31:0] i_mem_wdata = '0;
    logic [3:0]  i_mem_wstrb = '0;
    logic        o_mem_ready;
    logic [31:0] o_mem_rdata;
    logic [31:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        i_wb_ack = 1'b0;
    logic [31:0] i_wb_data = '0;
    logic        i_wb_stall = 1'b0;
    logic        i_wb_err = 1'b0;
    logic        o_bus_err;
    logic [31:0] o_err_addr;

    picorv32_wb_bridge #(.TIMEOUT(TMO), .ERR_RDATA(ERRV)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_mem_valid(i_mem_valid), .i_mem_instr(i_mem_instr),
        .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
        .i_mem_wstrb(i_mem_wstrb), .o_mem_ready(o_mem_ready),
        .o_mem_rdata(o_mem_rdata), .o_wb_addr(o_wb_addr),
        .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .i_wb_ack(i_wb_ack),
        .i_wb_data(i_wb_data), .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err),
        .o_bus_err(o_bus_err), .o_err_addr(o_err_addr)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Slave script: stall S cycles, respond L cycles after acceptance.
    // mode 0 ack, 1 err, 2 ack+err, 3 dead. Read data is ~addr unless fixed.
    int          sl_S = 0, sl_L = 0, sl_mode = 0, sl_k = 0;
    bit          sl_fix = 0;
    logic [31:0] sl_data = '0;
    bit          force_ack = 0, force_err = 0;

    always @(negedge i_clk) begin
        if (o_wb_cyc) begin
            bit resp;
            resp       = (sl_k == sl_S + sl_L) && (sl_mode != 3);
            i_wb_stall = (sl_k < sl_S);
            i_wb_ack   = resp && (sl_mode == 0 || sl_mode == 2);
            i_wb_err   = resp && (sl_mode == 1 || sl_mode == 2);
            i_wb_data  = sl_fix ? sl_data : ~o_wb_addr;
            sl_k++;
        end else begin
            i_wb_stall = 1'b0;
            i_wb_ack   = force_ack;
            i_wb_err   = force_err;
            i_wb_data  = 32'h0BAD_0BAD;
            sl_k       = 0;
        end
    end

    // Bus monitor
    int          m_cycles = 0, m_cyc_len = 0, m_stb_len = 0, m_rdy = 0;
    bit          m_unstable = 0, m_prev = 0;
    logic [31:0] m_addr, m_data;
    logic [3:0]  m_sel;
    logic        m_we;
    logic [31:0] m_addrs[$];

    always @(negedge i_clk) begin
        if (o_wb_cyc) begin
            if (!m_prev) begin
                m_cycles++;
                m_addrs.push_back(o_wb_addr);
                m_addr = o_wb_addr; m_data = o_wb_data;
                m_sel = o_wb_sel; m_we = o_wb_we;
                m_cyc_len = 0; m_stb_len = 0; m_unstable = 0;
            end else if ({o_wb_addr, o_wb_data, o_wb_sel, o_wb_we} !==
                         {m_addr, m_data, m_sel, m_we}) begin
                m_unstable = 1;
            end
            m_cyc_len++;
            if (o_wb_stb) m_stb_len++;
        end
        if (o_mem_ready) m_rdy++;
        m_prev = o_wb_cyc;
    end

    // Model state for the sticky error report
    bit          exp_bus_err = 0;
    logic [31:0] exp_err_addr = '0;

    task automatic slave_cfg(input int s, input int l, input int mode);
        sl_S = s; sl_L = l; sl_mode = mode; sl_fix = 0;
    endtask

    // Call just after a negedge; returns ready latency (-1 on budget expiry).
    task automatic cpu_xfer(input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] ws, output int lat,
                            output logic [31:0] rd);
        lat = -1; rd = '0;
        i_mem_valid = 1'b1; i_mem_addr = a;
        i_mem_wdata = wd; i_mem_wstrb = ws;
        i_mem_instr = $urandom_range(0, 1) == 1;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge i_clk);
            if (o_mem_ready) begin
                lat = c; rd = o_mem_rdata;
                break;
            end
        end
        i_mem_valid = 1'b0;
        @(negedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        repeat (3) @(negedge i_clk);
        n_cmp++;
        if ({o_mem_ready, o_mem_rdata, o_wb_addr, o_wb_data, o_wb_sel,
             o_wb_we, o_wb_cyc, o_wb_stb, o_bus_err, o_err_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b cyc=%b stb=%b err=%b addr=%h want all 0",
                     o_mem_ready, o_wb_cyc, o_wb_stb, o_bus_err, o_wb_addr);
        end
        i_reset_n = 1'b1;
        @(negedge i_clk);
        exp_bus_err = 0; exp_err_addr = '0;
    endtask

    task automatic test_zero_wait_read();
        int lat; logic [31:0] rd;
        slave_cfg(0, 0, 0);
        sl_fix = 1; sl_data = 32'h0000_1234;
        cpu_xfer(32'h8000_0000, 32'h0, 4'h0, lat, rd);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL zw_latency: got %0d want 2", lat); end
        n_cmp++; if (rd !== 32'h0000_1234) begin n_fail++; $display("FAIL zw_rdata: got %h want 00001234", rd); end
        n_cmp++;
        if ({m_addr, m_sel, m_we, m_stb_len, m_cyc_len} !== {32'h8000_0000, 4'hF, 1'b0, 32'd1, 32'd1}) begin
            n_fail++;
            $display("FAIL zw_bus: got addr=%h sel=%h we=%b stb=%0d cyc=%0d want 80000000 f 0 1 1",
                     m_addr, m_sel, m_we, m_stb_len, m_cyc_len);
        end
        sl_fix = 0;
    endtask

    task automatic test_stall_write();
        int lat; logic [31:0] rd;
        slave_cfg(3, 2, 0);
        cpu_xfer(32'h0000_0100, 32'hA5A5_5A5A, 4'b0011, lat, rd);
        n_cmp++; if (lat !== 7) begin n_fail++; $display("FAIL sw_latency: got %0d want 7", lat); end
        n_cmp++; if (m_stb_len !== 4) begin n_fail++; $display("FAIL sw_stb_len: got %0d want 4", m_stb_len); end
        n_cmp++; if (m_unstable !== 1'b0) begin n_fail++; $display("FAIL sw_stable: got unstable=%b want 0", m_unstable); end
        n_cmp++;
        if ({m_data, m_sel, m_we} !== {32'hA5A5_5A5A, 4'b0011, 1'b1}) begin
            n_fail++; $display("FAIL sw_fields: got %h %h %b want a5a55a5a 3 1", m_data, m_sel, m_we);
        end
        n_cmp++; if (o_bus_err !== 1'b0) begin n_fail++; $display("FAIL sw_bus_err: got %b want 0", o_bus_err); end
    endtask

    task automatic test_err();
        int lat; logic [31:0] rd;
        slave_cfg(0, 2, 1);
        cpu_xfer(32'h0000_2000, 32'h0, 4'h0, lat, rd);
        exp_bus_err = 1; exp_err_addr = 32'h0000_2000;
        n_cmp++; if (rd !== ERRV) begin n_fail++; $display("FAIL err_rdata: got %h want %h", rd, ERRV); end
        n_cmp++; if (o_bus_err !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b want 1", o_bus_err); end
        n_cmp++; if (o_err_addr !== exp_err_addr) begin n_fail++; $display("FAIL err_addr1: got %h want %h", o_err_addr, exp_err_addr); end
        slave_cfg(1, 0, 1);
        cpu_xfer(32'h0000_3000, 32'h0, 4'h0, lat, rd);
        n_cmp++; if (o_err_addr !== exp_err_addr) begin n_fail++; $display("FAIL err_addr2: got %h want %h", o_err_addr, exp_err_addr); end
        n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL err_latency2: got %0d want 3", lat); end
    endtask

    task automatic test_timeout();
        int lat; logic [31:0] rd;
        slave_cfg(0, 0, 3);
        cpu_xfer(32'h0000_4000, 32'h0, 4'h0, lat, rd);
        n_cmp++; if (lat !== TMO + 1) begin n_fail++; $display("FAIL tmo_latency: got %0d want %0d", lat, TMO + 1); end
        n_cmp++; if (m_cyc_len !== TMO) begin n_fail++; $display("FAIL tmo_cyc_len: got %0d want %0d", m_cyc_len, TMO); end
        n_cmp++; if (rd !== ERRV) begin n_fail++; $display("FAIL tmo_rdata: got %h want %h", rd, ERRV); end
        n_cmp++; if (o_bus_err !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: got %b want 1", o_bus_err); end
    endtask

    task automatic test_ack_err_both();
        int lat; logic [31:0] rd;
        slave_cfg(0, 1, 2);
        cpu_xfer(32'h0000_5000, 32'h0, 4'h0, lat, rd);
        n_cmp++; if (rd !== ERRV) begin n_fail++; $display("FAIL both_rdata: got %h want %h", rd, ERRV); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            int lat, s, l, mode, r;
            logic [31:0] a, wd, rd, rd_e;
            logic [3:0] ws;
            bit iserr;
            s = $urandom_range(0, 3); l = $urandom_range(0, 3);
            r = $urandom_range(0, 9);
            mode = (r < 7) ? 0 : (r == 7) ? 1 : 2;
            a = $urandom; wd = $urandom;
            ws = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            slave_cfg(s, l, mode);
            cpu_xfer(a, wd, ws, lat, rd);
            iserr = (mode != 0);
            rd_e = (ws != 0) ? 32'h0 : iserr ? ERRV : ~a;
            if (iserr && !exp_bus_err) exp_err_addr = a;
            if (iserr) exp_bus_err = 1;
            n_cmp++; if (lat !== 2 + s + l) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", it, lat, 2 + s + l); end
            if (!(iserr && ws != 0)) begin
                n_cmp++; if (rd !== rd_e) begin n_fail++; $display("FAIL rnd%0d_rdata: got %h want %h", it, rd, rd_e); end
            end
            n_cmp++;
            if ({m_addr, m_sel, m_we} !== {a, (ws != 0) ? ws : 4'hF, ws != 0}) begin
                n_fail++; $display("FAIL rnd%0d_req: got %h %h %b want %h ws=%h", it, m_addr, m_sel, m_we, a, ws);
            end
            if (ws != 0) begin
                n_cmp++; if (m_data !== wd) begin n_fail++; $display("FAIL rnd%0d_wdata: got %h want %h", it, m_data, wd); end
            end
            n_cmp++;
            if ({m_stb_len, m_cyc_len, m_unstable} !== {s + 1, s + l + 1, 1'b0}) begin
                n_fail++; $display("FAIL rnd%0d_shape: got stb=%0d cyc=%0d unst=%b want %0d %0d 0",
                                   it, m_stb_len, m_cyc_len, m_unstable, s + 1, s + l + 1);
            end
            n_cmp++;
            if ({o_bus_err, o_err_addr} !== {exp_bus_err, exp_err_addr}) begin
                n_fail++; $display("FAIL rnd%0d_sticky: got %b %h want %b %h", it, o_bus_err, o_err_addr, exp_bus_err, exp_err_addr);
            end
        end
    endtask

    task automatic test_back_to_back();
        int c0, r0, n;
        logic [31:0] rd_a, rd_b;
        bit got;
        slave_cfg(0, 0, 0);
        c0 = m_cycles; r0 = m_rdy;
        i_mem_valid = 1'b1; i_mem_addr = 32'h0000_A000; i_mem_wstrb = 4'h0;
        got = 0; rd_a = '0; rd_b = '0;
        for (n = 0; n < 50 && !got; n++) begin
            @(negedge i_clk);
            if (o_mem_ready) begin got = 1; rd_a = o_mem_rdata; end
        end
        // Valid stays high through the ready cycle with the next request.
        i_mem_addr = 32'h0000_B000;
        got = 0;
        for (n = 0; n < 50 && !got; n++) begin
            @(negedge i_clk);
            if (o_mem_ready) begin got = 1; rd_b = o_mem_rdata; end
        end
        i_mem_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        #1;
        n_cmp++; if (m_cycles - c0 !== 2) begin n_fail++; $display("FAIL b2b_cycles: got %0d want 2", m_cycles - c0); end
        n_cmp++; if (m_rdy - r0 !== 2) begin n_fail++; $display("FAIL b2b_ready: got %0d want 2", m_rdy - r0); end
        n_cmp++;
        if ({m_addrs[m_addrs.size() - 2], m_addrs[m_addrs.size() - 1]} !== {32'h0000_A000, 32'h0000_B000}) begin
            n_fail++; $display("FAIL b2b_addrs: got %h %h want 0000a000 0000b000",
                               m_addrs[m_addrs.size() - 2], m_addrs[m_addrs.size() - 1]);
        end
        n_cmp++;
        if ({rd_a, rd_b} !== {~32'h0000_A000, ~32'h0000_B000}) begin
            n_fail++; $display("FAIL b2b_rdata: got %h %h want %h %h", rd_a, rd_b, ~32'h0000_A000, ~32'h0000_B000);
        end
    endtask

    task automatic test_ack_idle();
        int c0, r0;
        c0 = m_cycles; r0 = m_rdy;
        force_ack = 1; force_err = 1;
        repeat (4) @(negedge i_clk);
        force_ack = 0; force_err = 0;
        repeat (2) @(negedge i_clk);
        #1;
        n_cmp++;
        if ({m_rdy - r0, m_cycles - c0} !== {32'd0, 32'd0}) begin
            n_fail++; $display("FAIL idle_ack: got ready=%0d cycles=%0d want 0 0", m_rdy - r0, m_cycles - c0);
        end
        n_cmp++;
        if ({o_bus_err, o_err_addr} !== {exp_bus_err, exp_err_addr}) begin
            n_fail++; $display("FAIL idle_sticky: got %b %h want %b %h", o_bus_err, o_err_addr, exp_bus_err, exp_err_addr);
        end
    endtask

    task automatic test_reset_in_wait();
        int lat; logic [31:0] rd;
        slave_cfg(0, 0, 3);
        i_mem_valid = 1'b1; i_mem_addr = 32'h0000_C000; i_mem_wstrb = 4'h0;
        repeat (4) @(negedge i_clk);
        n_cmp++;
        if ({o_wb_cyc, o_wb_stb} !== 2'b10) begin
            n_fail++; $display("FAIL rst_pre_wait: got cyc=%b stb=%b want 1 0", o_wb_cyc, o_wb_stb);
        end
        #2 i_reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({o_wb_cyc, o_wb_stb, o_mem_ready, o_bus_err} !== 4'b0000) begin
            n_fail++; $display("FAIL rst_async: got cyc=%b stb=%b rdy=%b err=%b want 0 0 0 0",
                               o_wb_cyc, o_wb_stb, o_mem_ready, o_bus_err);
        end
        i_mem_valid = 1'b0;
        exp_bus_err = 0; exp_err_addr = '0;
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(negedge i_clk);
        slave_cfg(0, 0, 0);
        cpu_xfer(32'h0000_D000, 32'h0, 4'h0, lat, rd);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL rst_after_latency: got %0d want 2", lat); end
        n_cmp++; if (rd !== ~32'h0000_D000) begin n_fail++; $display("FAIL rst_after_rdata: got %h want %h", rd, ~32'h0000_D000); end
    endtask

    initial begin
        test_reset();
        test_zero_wait_read();
        test_stall_write();
        test_err();
        test_timeout();
        test_ack_err_both();
        test_random();
        test_back_to_back();
        test_ack_idle();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
